// File: rtl/code_pkg.sv
// Shared types and helpers for the code sequence transmitter.
package code_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP_WAIT = 3'd3,
    ST_CANCEL   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Codeword sent when a sequence is cancelled.
  localparam logic [7:0] RESET_CODEWORD = 8'b1111_0000;

  // A digit codeword carries the inverted digit in the upper nibble.
  function automatic logic [7:0] encode_digit(input logic [3:0] d);
    return {~d, d};
  endfunction

endpackage

// File: rtl/gap_counter.sv
// 4-bit loadable down-counter that times the idle gap between codewords.
module gap_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q;

  // Load has priority; the count saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= 4'd0;
    else if (load)
      count_q <= load_val;
    else if (dec && (count_q != 4'd0))
      count_q <= count_q - 4'd1;
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/code_sequence_tx.sv
// Sends a key as a sequence of {~d, d} codewords over a valid/ready link,
// with an optional idle gap between codewords and an abort path that
// emits a reset codeword.
module code_sequence_tx
  import code_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int GAP      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4*N_DIGITS-1:0] key,
  input  logic                  ready,
  output logic [7:0]            code,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            sent_cnt
);

  localparam int         KW       = 4 * N_DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(N_DIGITS - 1);
  // The counter is checked before it is decremented, so GAP-1 gives GAP cycles.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t        state_q, state_d;
  logic [KW-1:0] shreg_q, shreg_d, shreg_shift;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gap_load, gap_dec, gap_zero;
  logic          accept;

  assign accept      = valid_q & ready;
  assign shreg_shift = shreg_q >> 4;

  gap_counter u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    code_d   = 8'h00;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          shreg_d = key;
          cnt_d   = 4'd0;
        end
      end
      ST_LOAD: begin
        valid_d = 1'b1;
        if (abort) begin
          state_d = ST_CANCEL;
          code_d  = RESET_CODEWORD;
        end else begin
          state_d = ST_SEND;
          code_d  = encode_digit(shreg_q[3:0]);
        end
      end
      ST_SEND: begin
        if (abort) begin
          // Abort wins over a same-cycle acceptance: the digit is not counted.
          state_d = ST_CANCEL;
          code_d  = RESET_CODEWORD;
          valid_d = 1'b1;
        end else if (accept) begin
          cnt_d   = cnt_q + 4'd1;
          shreg_d = shreg_shift;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d  = ST_GAP_WAIT;
            gap_load = 1'b1;
          end else begin
            code_d  = encode_digit(shreg_shift[3:0]);
            valid_d = 1'b1;
          end
        end else begin
          code_d  = code_q;
          valid_d = 1'b1;
        end
      end
      ST_GAP_WAIT: begin
        if (abort) begin
          state_d = ST_CANCEL;
          code_d  = RESET_CODEWORD;
          valid_d = 1'b1;
        end else if (gap_zero) begin
          state_d = ST_SEND;
          code_d  = encode_digit(shreg_q[3:0]);
          valid_d = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_CANCEL: begin
        if (accept) begin
          state_d = ST_IDLE;
        end else begin
          code_d  = RESET_CODEWORD;
          valid_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      // NOTE: the shift register is reset too; it is a small flop array, not
      // a RAM, and a clean value keeps its contents deterministic.
      state_q <= ST_IDLE;
      shreg_q <= '0;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign done     = done_q;
  assign sent_cnt = cnt_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_code_sequence_tx.sv
// Bench for code_sequence_tx: one instance with GAP=1, one with GAP=0.
module tb_code_sequence_tx;

  logic        clk = 1'b0;
  logic        reset, start, abort, ready, start0, ready0;
  logic [15:0] key;
  logic [7:0]  code, code0;
  logic        valid, busy, done, valid0, busy0, done0;
  logic [3:0]  sent_cnt, sent_cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic       d;
    logic       b;
  } obs_t;

  obs_t       exp_trace[$];
  logic [7:0] hs[$];
  int         done_cnt;

  always #5 clk = ~clk;

  code_sequence_tx #(.N_DIGITS(4), .GAP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .key(key),
    .ready(ready), .code(code), .valid(valid), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  code_sequence_tx #(.N_DIGITS(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(1'b0), .key(key),
    .ready(ready0), .code(code0), .valid(valid0), .busy(busy0), .done(done0),
    .sent_cnt(sent_cnt0)
  );

  // Record the codewords the GAP=1 instance actually hands over, and done pulses.
  always @(posedge clk) begin
    if (reset) begin
      if (valid && ready && !abort) hs.push_back(code);
      if (done) done_cnt++;
    end
  end

  // Reference encoding: upper nibble is 15 minus the digit.
  function automatic logic [7:0] model_cw(input logic [3:0] d);
    return 8'((15 - int'(d)) * 16 + int'(d));
  endfunction

  // Expected per-cycle outputs from the cycle after start is sampled, ready held at 1.
  function automatic void build_trace(input logic [15:0] k, input int gap);
    exp_trace.delete();
    exp_trace.push_back('{1'b0, 8'h00, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      exp_trace.push_back('{1'b1, model_cw(k[4*i +: 4]), 1'b0, 1'b1});
      if (i < 3)
        for (int g = 0; g < gap; g++) exp_trace.push_back('{1'b0, 8'h00, 1'b0, 1'b1});
    end
    exp_trace.push_back('{1'b0, 8'h00, 1'b1, 1'b1});
    exp_trace.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
  endfunction

  // Expected handshake list packed as {count, codewords...}.
  function automatic logic [63:0] pack_exp(input logic [15:0] k, input int n_ok, input bit aborted);
    logic [63:0] r = '0;
    int          n = 0;
    for (int i = 0; i < n_ok; i++) begin
      r = (r << 8) | 64'(model_cw(k[4*i +: 4]));
      n++;
    end
    if (aborted) begin
      r = (r << 8) | 64'hF0;
      n++;
    end
    return r | (64'(n) << 56);
  endfunction

  function automatic logic [63:0] pack_hs();
    logic [63:0] r = '0;
    foreach (hs[i]) r = (r << 8) | 64'(hs[i]);
    return r | (64'(hs.size()) << 56);
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    start0 = 1'b0; ready0 = 1'b0; key = 16'h0000;
    #12;
    n_checks++;
    if ({code, valid, busy, done, sent_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got code=%h valid=%b busy=%b done=%b cnt=%0d, expected all zero",
               code, valid, busy, done, sent_cnt);
    end
    n_checks++;
    if ({code0, valid0, busy0, done0, sent_cnt0} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_gap0: got code=%h valid=%b busy=%b, expected all zero",
               code0, valid0, busy0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got valid=%b busy=%b, expected 0 0", valid, busy);
    end
  endtask

  task automatic test_nominal();
    build_trace(16'h3215, 1);
    hs.delete(); done_cnt = 0;
    key = 16'h3215; ready = 1'b1; start = 1'b1;
    foreach (exp_trace[i]) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({valid, code, done, busy} !== exp_trace[i]) begin
        n_fail++;
        $display("FAIL nominal_cycle%0d: got v=%b code=%h done=%b busy=%b, expected v=%b code=%h done=%b busy=%b",
                 i, valid, code, done, busy, exp_trace[i].v, exp_trace[i].c, exp_trace[i].d, exp_trace[i].b);
      end
    end
    n_checks++;
    if (sent_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL nominal_sent_cnt: got %0d, expected 4", sent_cnt);
    end
    n_checks++;
    if (pack_hs() !== pack_exp(16'h3215, 4, 1'b0)) begin
      n_fail++;
      $display("FAIL nominal_handshakes: got %h, expected %h", pack_hs(), pack_exp(16'h3215, 4, 1'b0));
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    bit held = 1'b0;
    hs.delete(); done_cnt = 0;
    key = 16'h3215; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 200) begin
      if (!held && !valid && sent_cnt == 4'd1) begin
        held  = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_checks++;
          if ({valid, code} !== {1'b1, 8'hE1}) begin
            n_fail++;
            $display("FAIL backpressure_hold%0d: got v=%b code=%h, expected v=1 code=e1", k, valid, code);
          end
        end
        ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy || !held) begin
      n_fail++;
      $display("FAIL backpressure_timeout: got busy=%b held=%b, expected 0 1", busy, held);
    end
    n_checks++;
    if (pack_hs() !== pack_exp(16'h3215, 4, 1'b0) || done_cnt != 1 || sent_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL backpressure_result: got hs=%h done=%0d cnt=%0d, expected hs=%h done=1 cnt=4",
               pack_hs(), done_cnt, sent_cnt, pack_exp(16'h3215, 4, 1'b0));
    end
  endtask

  task automatic test_abort();
    int cyc = 0;
    hs.delete(); done_cnt = 0;
    key = 16'h3215; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(valid && code == 8'hD2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({valid, code, sent_cnt, busy} !== {1'b1, 8'hF0, 4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_cancel: got v=%b code=%h cnt=%0d busy=%b, expected v=1 code=f0 cnt=2 busy=1",
               valid, code, sent_cnt, busy);
    end
    @(negedge clk);
    n_checks++;
    if ({valid, busy, sent_cnt} !== {1'b0, 1'b0, 4'd2} || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_idle: got v=%b busy=%b cnt=%0d done=%0d, expected 0 0 2 0",
               valid, busy, sent_cnt, done_cnt);
    end
    n_checks++;
    if (pack_hs() !== pack_exp(16'h3215, 2, 1'b1)) begin
      n_fail++;
      $display("FAIL abort_handshakes: got %h, expected %h", pack_hs(), pack_exp(16'h3215, 2, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    key = 16'h3215; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(busy && !valid && sent_cnt == 4'd1) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({code, valid, busy, done, sent_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got code=%h valid=%b busy=%b cnt=%0d, expected all zero",
               code, valid, busy, sent_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({valid, busy, code} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got v=%b busy=%b code=%h, expected idle", valid, busy, code);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({valid, code} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got v=%b code=%h, expected v=1 code=a5", valid, code);
    end
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    build_trace(16'h3215, 0);
    ready0 = 1'b1; start0 = 1'b1;
    foreach (exp_trace[i]) begin
      @(negedge clk);
      start0 = (i == 2);
      n_checks++;
      if ({valid0, code0, done0, busy0} !== exp_trace[i]) begin
        n_fail++;
        $display("FAIL gap0_cycle%0d: got v=%b code=%h done=%b busy=%b, expected v=%b code=%h done=%b busy=%b",
                 i, valid0, code0, done0, busy0, exp_trace[i].v, exp_trace[i].c, exp_trace[i].d, exp_trace[i].b);
      end
    end
    start0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({valid0, busy0} !== 2'b00) begin
        n_fail++;
        $display("FAIL gap0_no_second_seq%0d: got v=%b busy=%b, expected 0 0", k, valid0, busy0);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    bit          do_abort, aborted;
    int          ab_at, cyc, n_ok;
    logic        pv, pr, pa;
    logic [7:0]  pc;
    for (int it = 0; it < 20; it++) begin
      k        = 16'($urandom);
      do_abort = ($urandom_range(0, 3) == 0);
      ab_at    = $urandom_range(0, 3);
      aborted  = 1'b0;
      hs.delete(); done_cnt = 0;
      key = k; abort = 1'b0; ready = 1'($urandom); start = 1'b1;
      pv = 1'b0; pr = 1'b0; pa = 1'b0; pc = 8'h00;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
        if (pv && !pr && !pa) begin
          n_checks++;
          if ({valid, code} !== {1'b1, pc}) begin
            n_fail++;
            $display("FAIL random%0d_stable: got v=%b code=%h, expected v=1 code=%h", it, valid, code, pc);
          end
        end
        pv    = valid;
        pc    = code;
        abort = 1'b0;
        if (do_abort && !aborted && valid && sent_cnt == 4'(ab_at)) begin
          abort   = 1'b1;
          aborted = 1'b1;
        end
        ready = 1'($urandom);
        pr    = ready;
        pa    = abort;
        @(negedge clk);
        cyc++;
      end
      abort = 1'b0;
      n_ok  = aborted ? ab_at : 4;
      n_checks++;
      if (busy) begin
        n_fail++;
        $display("FAIL random%0d_timeout: got busy=1 after %0d cycles, expected idle", it, cyc);
      end
      n_checks++;
      if (pack_hs() !== pack_exp(k, n_ok, aborted) || sent_cnt !== 4'(n_ok)
          || done_cnt != (aborted ? 0 : 1)) begin
        n_fail++;
        $display("FAIL random%0d_result: got hs=%h cnt=%0d done=%0d, expected hs=%h cnt=%0d done=%0d",
                 it, pack_hs(), sent_cnt, done_cnt, pack_exp(k, n_ok, aborted), n_ok, aborted ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
